mod_counter_ctrl: RTL and testbench

//  Parametrised, programmable modulo counter: up/down, free-run or one-shot.

---
 rtl/mod_counter_ctrl.sv | 153 +++++++++++++++
 tb/tb_mod_counter_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter_ctrl.sv
// Programmable modulo counter: up/down, free-run or one-shot, registered tc pulse.
// Optional prescaler enabled by defining MODCNT_PRESCALE_EN.
module mod_counter_ctrl #(
    parameter int WIDTH    = 7,
    parameter int MODULO   = 100,
    parameter int PRESCALE = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             dir,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_val,
    output logic             load_rdy,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(MODULO - 1);

    if (MODULO < 1 || (MODULO - 1) >= (2 ** WIDTH)) begin : g_bad_modulo
        $error("MODULO-1 must fit in WIDTH bits");
    end

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             tc_q, tc_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             step;
    logic             at_term;

`ifdef MODCNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
`endif

    assign load_rdy = (state_q == IDLE);
    assign cnt      = cnt_q;
    assign tc       = tc_q;
    assign busy     = (state_q == RUN);

    // Terminal value depends on the direction latched at start.
    assign at_term = dir_q ? (cnt_q == '0) : (cnt_q == period_q);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= PERIOD_RST;
            tc_q     <= 1'b0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
`ifdef MODCNT_PRESCALE_EN
            presc_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tc_q     <= tc_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
`ifdef MODCNT_PRESCALE_EN
            presc_q  <= presc_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        tc_d     = 1'b0;
        mode_d   = mode_q;
        dir_d    = dir_q;
        step     = 1'b0;
`ifdef MODCNT_PRESCALE_EN
        presc_d  = presc_q;
`endif

        if (load_vld && load_rdy) begin
            period_d = load_val;
        end

        unique case (state_q)
            IDLE: begin
                // A same-cycle load is already visible in period_d.
                if (start && !stop) begin
                    state_d = RUN;
                    mode_d  = mode;
                    dir_d   = dir;
                    cnt_d   = dir ? period_d : '0;
`ifdef MODCNT_PRESCALE_EN
                    presc_d = '0;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
`ifdef MODCNT_PRESCALE_EN
                    presc_d = '0;
`endif
                end else begin
`ifdef MODCNT_PRESCALE_EN
                    if (en) begin
                        if (presc_q == PS_LAST) begin
                            presc_d = '0;
                            step    = 1'b1;
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
`else
                    step = en;
`endif
                    if (step) begin
                        if (at_term) begin
                            cnt_d = dir_q ? period_q : '0;
                            tc_d  = 1'b1;
                            if (mode_q) begin
                                state_d = IDLE;
                            end
                        end else if (dir_q) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed vector bench for mod_counter_ctrl (default build, no prescaler).
module tb_mod_counter_ctrl;

    localparam int W = 7;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         en = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         mode = 1'b0;
    logic         dir = 1'b0;
    logic         load_vld = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         load_rdy;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic         rst;
        logic         en;
        logic         start;
        logic         stop;
        logic         mode;
        logic         dir;
        logic         lv;
        logic [W-1:0] lval;
        logic [W-1:0] e_cnt;
        logic         e_tc;
        logic         e_busy;
        logic         e_rdy;
    } vec_t;

    vec_t vq[$];

    mod_counter_ctrl #(.WIDTH(W), .MODULO(100), .PRESCALE(10)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir      (dir),
        .load_vld (load_vld),
        .load_val (load_val),
        .load_rdy (load_rdy),
        .cnt      (cnt),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic add(input logic r, e, s, p, m, d, lv,
                       input int lval, ec, input logic et, eb, er);
        vec_t v;
        v.rst = r; v.en = e; v.start = s; v.stop = p;
        v.mode = m; v.dir = d; v.lv = lv; v.lval = W'(lval);
        v.e_cnt = W'(ec); v.e_tc = et; v.e_busy = eb; v.e_rdy = er;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, e, s, p, m, d, lv, input int lval);
        sys_rst = r; en = e; start = s; stop = p;
        mode = m; dir = d; load_vld = lv; load_val = W'(lval);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int ec,
                              input logic et, eb, er);
        check({nm, ".cnt"}, int'(cnt), ec);
        check({nm, ".tc"}, int'(tc), int'(et));
        check({nm, ".busy"}, int'(busy), int'(eb));
        check({nm, ".rdy"}, int'(load_rdy), int'(er));
    endtask

    initial begin
        int ec;
        logic et;

        //   rst en st sp md dr lv lval  cnt tc bs rdy
        add(1, 0, 0, 0, 0, 0, 0, 0,    0,  0, 0, 1); // reset
        add(0, 0, 0, 0, 0, 0, 1, 4,    0,  0, 0, 1); // load 4
        add(0, 1, 1, 0, 1, 1, 0, 0,    4,  0, 1, 0); // one-shot down
        add(0, 1, 0, 0, 0, 0, 0, 0,    3,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    2,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    1,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    0,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    4,  1, 0, 1); // terminal
        add(0, 1, 0, 0, 0, 0, 0, 0,    4,  0, 0, 1); // no more tc
        add(0, 0, 1, 0, 0, 0, 0, 0,    0,  0, 1, 0); // free-run up
        add(0, 0, 0, 0, 0, 0, 1, 9,    0,  0, 1, 0); // load in RUN
        add(0, 1, 0, 0, 0, 0, 1, 9,    1,  0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,    1,  0, 1, 0); // en low holds
        add(0, 1, 0, 0, 0, 0, 0, 0,    2,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    3,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    4,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    0,  1, 1, 0); // period still 4
        add(0, 1, 0, 0, 0, 0, 0, 0,    1,  0, 1, 0);
        add(0, 1, 0, 1, 0, 0, 1, 9,    1,  0, 0, 1); // stop
        add(0, 0, 0, 0, 0, 0, 1, 9,    1,  0, 0, 1); // load 9 accepted
        add(0, 1, 1, 1, 0, 1, 0, 0,    1,  0, 0, 1); // stop beats start
        add(0, 1, 1, 0, 0, 1, 0, 0,    9,  0, 1, 0); // down from 9
        add(0, 1, 0, 0, 0, 0, 0, 0,    8,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    7,  0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,    6,  0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0,    0,  0, 0, 1); // reset mid-run
        add(0, 0, 1, 0, 0, 1, 0, 0,   99,  0, 1, 0); // period back to 99
        add(0, 1, 0, 1, 0, 0, 0, 0,   99,  0, 0, 1);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].en, vq[i].start, vq[i].stop,
                  vq[i].mode, vq[i].dir, vq[i].lv, int'(vq[i].lval));
            expect_out($sformatf("vec%0d", i), int'(vq[i].e_cnt),
                       vq[i].e_tc, vq[i].e_busy, vq[i].e_rdy);
        end

        // Free-run up with period 99 for two full periods.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        expect_out("fr_start", 0, 1'b0, 1'b1, 1'b0);
        ec = 0;
        for (int i = 0; i < 200; i++) begin
            et = (ec == 99);
            ec = (ec == 99) ? 0 : ec + 1;
            drive(0, 1, 0, 0, 0, 0, 0, 0);
            check($sformatf("fr%0d.cnt", i), int'(cnt), ec);
            check($sformatf("fr%0d.tc", i), int'(tc), int'(et));
        end

        // Reset while cnt is 50 in RUN.
        for (int i = 0; i < 50; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
        check("at50.cnt", int'(cnt), 50);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        expect_out("rst50", 0, 1'b0, 1'b0, 1'b1);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        expect_out("restart", 0, 1'b0, 1'b1, 1'b0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("restart1", 1, 1'b0, 1'b1, 1'b0);

        // Period 0, loaded in the same cycle as an up start.
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 1, 0);
        expect_out("p0_start", 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0);
            expect_out($sformatf("p0_%0d", i), 0, 1'b1, 1'b1, 1'b0);
        end

        // Same-cycle load and down start uses the new period.
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 1, 1, 6);
        expect_out("ld_dn", 6, 1'b0, 1'b1, 1'b0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("ld_dn1", 5, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
